fire8_squeeze_ofm_writer: RTL and testbench

Output-side partner of the fire8 squeeze layer. Captures the DSP_NO-wide output feature-map word bus on each sample pulse, serializes it into a single-port feature-map RAM in channel-major order for the fire8 expand layers, and returns `ram_feedback` once all WOUT² pixels are stored and the layer has signalled finish. Sits between the squeeze core and the fire8 ifm RAM.

---
 rtl/fire8_squeeze_ofm_writer.sv | 113 +++++++++++
 tb/tb_fire8_squeeze_ofm_writer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fire8_squeeze_ofm_writer.sv
// Fire8 squeeze output writer: captures one DSP_NO-word output sample and writes it
// channel-major (addr = BASE_ADDR + ch*WOUT^2 + pix) into the expand-layer input RAM.
module fire8_squeeze_ofm_writer #(
  parameter int unsigned WOUT      = 8,
  parameter int unsigned DSP_NO    = 112,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  input  logic              layer_finish,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  output logic              ram_feedback,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned NPIX  = WOUT * WOUT;
  localparam int unsigned PIX_W = $clog2(NPIX) + 1;
  localparam int unsigned CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, WAIT_FIN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   cap_buf [0:DSP_NO-1];
  logic [CH_W-1:0]    ch;
  logic [PIX_W-1:0]   pix;
  logic [ADDR_W-1:0]  addr;

  logic               last_ch;
  logic [CH_W-1:0]    ch_nxt;
  logic [PIX_W-1:0]   pix_inc;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [ADDR_W-1:0]  start_addr;
  logic               capture;

  assign last_ch  = (ch == CH_W'(DSP_NO - 1));
  assign ch_nxt   = ch + CH_W'(1);
  assign pix_inc  = pix + PIX_W'(1);
  assign addr_nxt = addr + ADDR_W'(NPIX);

  // A sample is accepted from IDLE, or back-to-back on the final channel of a non-final pixel.
  assign capture = layer_sample &&
                   (((state == IDLE) && (pix < PIX_W'(NPIX))) ||
                    ((state == DRAIN) && last_ch && (pix_inc != PIX_W'(NPIX))));

  assign start_addr = ADDR_W'(BASE_ADDR) +
                      ADDR_W'((state == DRAIN) ? pix_inc : pix);

  always_ff @(posedge clk) begin
    if (capture) cap_buf <= ofm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      pix          <= '0;
      addr         <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      ram_feedback <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      ram_feedback <= 1'b0;
      case (state)
        IDLE: ;
        DRAIN: begin
          if (!last_ch) begin
            ch       <= ch_nxt;
            addr     <= addr_nxt;
            ram_addr <= addr_nxt;
            ram_din  <= cap_buf[ch_nxt];
            if (layer_sample) overflow <= 1'b1;
          end else begin
            pix    <= pix_inc;
            ch     <= '0;
            ram_we <= 1'b0;
            busy   <= 1'b0;
            state  <= (pix_inc == PIX_W'(NPIX)) ? WAIT_FIN : IDLE;
          end
        end
        WAIT_FIN: begin
          if (layer_finish) begin
            state        <= DONE;
            ram_feedback <= 1'b1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase

      // First write of a newly captured pixel goes out on the following cycle.
      if (capture) begin
        state    <= DRAIN;
        ch       <= '0;
        addr     <= start_addr;
        ram_we   <= 1'b1;
        busy     <= 1'b1;
        ram_addr <= start_addr;
        ram_din  <= ofm[0];
      end
    end
  end

endmodule

// File: tb/tb_fire8_squeeze_ofm_writer.sv
// Scoreboard bench for fire8_squeeze_ofm_writer: a cycle-tagged model of expected
// RAM writes, overflow and feedback is checked by an independent monitor.
module tb_fire8_squeeze_ofm_writer;

  localparam int unsigned WOUT      = 8;
  localparam int unsigned DSP_NO    = 112;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned BASE_ADDR = 0;
  localparam int          NPIX      = WOUT * WOUT;
  localparam int          BIG       = 32'h7fffffff;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              layer_sample = 1'b0;
  logic              layer_finish = 1'b0;
  logic [WIDTH-1:0]  ofm  [0:DSP_NO-1];
  logic [WIDTH-1:0]  stim [0:DSP_NO-1];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_din;
  logic              ram_feedback;
  logic              busy;
  logic              overflow;

  fire8_squeeze_ofm_writer #(
    .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .layer_sample(layer_sample), .ofm(ofm),
    .layer_finish(layer_finish), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_feedback(ram_feedback), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  acc, drain_end, ovf_from, ovf_hold, fin_from, fb_cyc;
  bit  fb_done;
  int  n_vec = 0, n_err = 0, fb_seen = 0;
  bit  check_en = 1'b0;
  logic [WIDTH-1:0] shadow [0:(1<<ADDR_W)-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_reset(input int r);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > r) exp_q.pop_back();
    ovf_hold  = (ovf_from <= r) ? r : -1;
    ovf_from  = BIG;
    acc       = 0;
    drain_end = -1;
    fin_from  = BIG;
    fb_done   = 1'b0;
    if (fb_cyc > r) fb_cyc = -1;
  endfunction

  // A sample at t writes channel c at t+1+c; overlap with a running drain is dropped.
  function automatic void model_sample(input int t);
    if (t < drain_end) begin
      if (ovf_from > t + 1) ovf_from = t + 1;
    end else if (acc < NPIX) begin
      for (int c = 0; c < int'(DSP_NO); c++)
        exp_q.push_back('{t + 1 + c, ADDR_W'(int'(BASE_ADDR) + c * NPIX + acc), stim[c]});
      acc++;
      drain_end = t + int'(DSP_NO);
      if (acc == NPIX) fin_from = drain_end + 1;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_sample();
    ofm = stim;
    layer_sample = 1'b1;
    model_sample(cyc);
    step(1);
    layer_sample = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset(cyc);
    step(1);
    rst = 1'b0;
  endtask

  task automatic rand_stim();
    for (int i = 0; i < int'(DSP_NO); i++) stim[i] = WIDTH'($urandom);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      wr_t e;
      bit  exp_we;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("write_missing", 32'(0), 32'(1));
        void'(exp_q.pop_front());
      end
      exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      chk("busy", 32'(busy), 32'(exp_we));
      if (exp_we) begin
        e = exp_q.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(e.addr));
        chk("ram_din", 32'(ram_din), 32'(e.data));
      end
      if (ram_we === 1'b1) shadow[ram_addr] = ram_din;
      chk("overflow", 32'(overflow), 32'((cyc >= ovf_from) || (cyc == ovf_hold)));
      chk("ram_feedback", 32'(ram_feedback), 32'(cyc == fb_cyc));
      if (ram_feedback === 1'b1) fb_seen++;
      if (!fb_done && acc == NPIX && cyc >= fin_from && layer_finish && !rst) begin
        fb_done = 1'b1;
        fb_cyc  = cyc + 1;
      end
    end
  end

  initial begin
    acc = 0; drain_end = -1; ovf_from = BIG; ovf_hold = -1;
    fin_from = BIG; fb_cyc = -1; fb_done = 1'b0;
    for (int i = 0; i < int'(DSP_NO); i++) begin
      stim[i] = '0;
      ofm[i]  = '0;
    end
    step(3);
    rst = 1'b0;
    check_en = 1'b1;
    step(5);

    // single sample with ofm[i]=i+1
    for (int i = 0; i < int'(DSP_NO); i++) stim[i] = WIDTH'(i + 1);
    do_sample();
    step(130);

    // second sample 50 cycles into a drain is dropped; next one writes pixel 1
    do_reset(); step(3);
    rand_stim(); do_sample();
    step(49);
    rand_stim(); do_sample();
    step(100);
    rand_stim(); do_sample();
    step(130);

    // back-to-back samples DSP_NO apart
    do_reset(); step(3);
    rand_stim(); do_sample();
    step(int'(DSP_NO) - 1);
    rand_stim(); do_sample();
    step(250);

    // reset in the middle of a drain
    do_reset(); step(3);
    rand_stim(); do_sample();
    step(39);
    do_reset();
    step(5);
    rand_stim(); do_sample();
    step(130);

    // full layer with (p<<8)|i words, finish raised afterwards
    do_reset(); step(3);
    fb_seen = 0;
    for (int p = 0; p < NPIX; p++) begin
      for (int i = 0; i < int'(DSP_NO); i++) stim[i] = WIDTH'((p << 8) | i);
      do_sample();
      step(int'($urandom_range(180, 112)) - 1);
    end
    step(40);
    chk("mem_197", 32'(shadow[197]), 32'h0503);
    layer_finish = 1'b1;
    step(5);
    layer_finish = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_stim(); do_sample(); step(150);
    end
    chk("fb_count_a", 32'(fb_seen), 32'(1));

    // finish held from reset, random spacing including dropped samples
    layer_finish = 1'b1;
    do_reset(); step(3);
    fb_seen = 0;
    while (acc < NPIX) begin
      rand_stim(); do_sample();
      step(int'($urandom_range(170, 90)) - 1);
    end
    step(150);
    rand_stim(); do_sample();
    step(300);
    chk("fb_count_b", 32'(fb_seen), 32'(1));
    layer_finish = 1'b0;

    step(5);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
